s2cif_responder: RTL and testbench
==================================

// Module: s2cif_responder
// PURPOSE
//  RTL-side responder for the s2cif packet protocol (pkt_s: id, fn, ret, data[S2CIF_DATA_SIZE]).
//  Accepts a request packet as a word stream, executes fn on a local 32-bit register file,
//  and returns a response packet with the same id/fn, a ret code and result data.
//  Packets are serialized one word per beat; one request is in flight at a time.
// PARAMETERS
//  DATA_SIZE  16  data words per packet (matches S2CIF_DATA_SIZE); packet length = DATA_SIZE+3
//  NREG       64  register file depth (power of 2); AW = $clog2(NREG)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   reset; synchronous and active-high
//  req_valid  in   1   request word valid
//  req_ready  out  1   responder accepts request word
//  req_data   in   32  request word: beat0 id, beat1 fn, beat2 ret (ignored), beat3+k data[k]
//  req_last   in   1   marks final request word (must be beat DATA_SIZE+2)
//  rsp_valid  out  1   response word valid
//  rsp_ready  in   1   consumer accepts response word
//  rsp_data   out  32  response word: beat0 id, beat1 fn, beat2 ret, beat3+k data[k]
//  rsp_last   out  1   high on response beat DATA_SIZE+2
//  busy       out  1   high from first accepted request beat until last response beat accepted
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0; state RX, beat counter 0.
//   Register file is not reset. Reset mid-packet abandons RX/EXEC/TX; no partial response.
//  Transfer: a beat moves when valid&&ready in the same cycle. rsp_data/rsp_last held stable
//   while rsp_valid&&!rsp_ready.
//  States: RX -> (DRAIN) -> EXEC -> TX -> RX.
//   RX: req_ready=1 (from first cycle after reset). Beats stored into id/fn/data buffer by counter.
//    req_last on beat < DATA_SIZE+2: ret=2 (framing), go EXEC with op suppressed.
//    beat DATA_SIZE+2 without req_last: ret=2, go DRAIN.
//   DRAIN: req_ready=1, discard beats until req_last accepted, then EXEC (op suppressed).
//   EXEC: req_ready=0. One register access per cycle; always >=1 cycle.
//   TX: emits DATA_SIZE+3 beats; rsp_valid may be high the cycle after EXEC ends.
//    After last beat accepted: busy=0, next cycle RX with req_ready=1.
//  fn codes (ret checks only when no framing error):
//   0 NOP:   ret=0, data echoed.
//   1 WRITE: addr=data[0], n=data[1]; reg[(addr+i) mod NREG]=data[2+i], i=0..n-1.
//            ret=1 if addr>=NREG or n>DATA_SIZE-2 (no writes). n=0 legal, ret=0. data echoed.
//   2 READ:  addr=data[0], n=data[1]; rsp data[i]=reg[(addr+i) mod NREG], i<n; data[i]=0, i>=n.
//            ret=1 if addr>=NREG or n>DATA_SIZE (data all 0). n=0: ret=0, data all 0.
//   other:   ret=32'hFFFF_FFFF, data echoed.
//  ret=2 (framing): response id/fn from captured beats (0 if not received), data echoed as stored.
//  Address arithmetic in AW bits: wrap from NREG-1 to 0 without error.
//  EXEC length = max(n,1) cycles for valid WRITE/READ, else 1 cycle.
//  Latency: last req beat at cycle T -> first rsp beat valid at T+1+EXEC length (rsp_ready=1).
//  Back-to-back WRITE then READ: READ observes all WRITE data (no bypass hazard).
// TESTING
//  1 WRITE id=7 addr=4 n=3 data 11,22,33; then READ id=8 addr=4 n=3 -> rsp id=8 fn=2 ret=0
//    data[0..2]=11,22,33, data[3..15]=0; first rsp beat 4 cycles after last req beat.
//  2 Wrap: WRITE addr=62 n=4 vals A,B,C,D; READ addr=0 n=2 -> data A? no: data[0..1]=C,D, ret=0.
//  3 Errors: READ addr=64 -> ret=1 data all 0; WRITE n=15 -> ret=1, reg untouched; fn=9 -> ret=FFFFFFFF.
//  4 Framing: req_last on beat 5 -> ret=2, no reg change; 22 beats, last on 21 -> DRAIN, ret=2,
//    exactly 19 rsp beats, rsp_last only on beat 18.
//  5 Backpressure: rsp_ready toggled randomly -> rsp_data stable while stalled, req_ready=0 during TX.
//  6 Reset asserted mid-RX and mid-TX -> next cycle rsp_valid=0, busy=0; fresh NOP id=1 returns ret=0.

Source files
------------

// File: rtl/s2cif_responder.sv
// s2cif packet responder: receives a request packet one word per beat, runs the
// requested register-file operation, then streams back the response packet.
module s2cif_responder #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned NREG      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic        req_last,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy
);
  localparam int unsigned AW      = $clog2(NREG);
  localparam int unsigned PKT_LEN = DATA_SIZE + 3;
  localparam int unsigned CW      = $clog2(PKT_LEN);
  localparam int unsigned DIW     = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] LastBeat = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {StRx, StDrain, StExec, StTx} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   exec_cnt_q;
  logic            busy_q;
  logic            frame_q;
  logic [31:0]     id_q, fn_q, ret_q;
  // addr/n are kept apart from data_q because READ results overwrite data[0..1]
  logic [31:0]     addr_q, n_q;
  logic [31:0]     data_q [DATA_SIZE];
  logic [31:0]     rf [NREG];

  logic            req_fire, rsp_fire;
  logic            is_write, is_read, addr_ok, wr_ok, rd_ok, op_ok;
  logic [CW-1:0]   n_small, exec_len;
  logic            exec_done;
  logic [31:0]     ret_code;
  logic [AW-1:0]   rf_idx;
  logic [DIW-1:0]  rx_sel, exec_sel, wr_sel;

  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign is_write  = (fn_q == 32'd1);
  assign is_read   = (fn_q == 32'd2);
  assign addr_ok   = (addr_q < NREG);
  assign wr_ok     = addr_ok && (n_q <= DATA_SIZE - 2);
  assign rd_ok     = addr_ok && (n_q <= DATA_SIZE);
  assign op_ok     = !frame_q && ((is_write && wr_ok) || (is_read && rd_ok));
  // n_q fits in CW bits whenever op_ok holds
  assign n_small   = CW'(n_q);
  assign exec_len  = (op_ok && n_q != 32'd0) ? n_small : CW'(1);
  assign exec_done = (exec_cnt_q == exec_len - CW'(1));
  assign rf_idx    = addr_q[AW-1:0] + AW'(exec_cnt_q);
  assign rx_sel    = DIW'(cnt_q - CW'(3));
  assign exec_sel  = DIW'(exec_cnt_q);
  assign wr_sel    = DIW'(exec_cnt_q + CW'(2));
  assign busy      = busy_q;

  // Return code for a well-framed request
  always_comb begin
    ret_code = 32'hFFFF_FFFF;
    if (fn_q == 32'd0) ret_code = 32'd0;
    else if (is_write) ret_code = wr_ok ? 32'd0 : 32'd1;
    else if (is_read)  ret_code = rd_ok ? 32'd0 : 32'd1;
  end

  // Next-state and handshake/response outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_data  = 32'd0;
    unique case (state_q)
      StRx: begin
        req_ready = !rst;
        if (req_fire) begin
          if (req_last)              state_d = StExec;
          else if (cnt_q == LastBeat) state_d = StDrain;
        end
      end
      StDrain: begin
        req_ready = !rst;
        if (req_fire && req_last) state_d = StExec;
      end
      StExec: begin
        if (exec_done) state_d = StTx;
      end
      StTx: begin
        rsp_valid = 1'b1;
        rsp_last  = (cnt_q == LastBeat);
        if (cnt_q == CW'(0))      rsp_data = id_q;
        else if (cnt_q == CW'(1)) rsp_data = fn_q;
        else if (cnt_q == CW'(2)) rsp_data = ret_q;
        else                      rsp_data = data_q[rx_sel];
        if (rsp_fire && rsp_last) state_d = StRx;
      end
      default: state_d = StRx;
    endcase
  end

  // State, beat counters and packet buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRx;
      cnt_q      <= '0;
      exec_cnt_q <= '0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
      id_q       <= '0;
      fn_q       <= '0;
      ret_q      <= '0;
      addr_q     <= '0;
      n_q        <= '0;
      data_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StRx: begin
          if (req_fire) begin
            busy_q <= 1'b1;
            cnt_q  <= (req_last || cnt_q == LastBeat) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(0)) id_q <= req_data;
            if (cnt_q == CW'(1)) fn_q <= req_data;
            if (cnt_q == CW'(3)) addr_q <= req_data;
            if (cnt_q == CW'(4)) n_q <= req_data;
            if (cnt_q >= CW'(3)) data_q[rx_sel] <= req_data;
            // last flag must coincide exactly with the final beat
            if (req_last != (cnt_q == LastBeat)) begin
              frame_q <= 1'b1;
              ret_q   <= 32'd2;
            end
          end
        end
        StDrain: ;
        StExec: begin
          exec_cnt_q <= exec_done ? '0 : exec_cnt_q + CW'(1);
          if (!frame_q && exec_cnt_q == '0) ret_q <= ret_code;
          if (!frame_q && is_read && exec_cnt_q == '0) data_q <= '{default: '0};
          if (op_ok && is_read && exec_cnt_q < n_small) data_q[exec_sel] <= rf[rf_idx];
        end
        StTx: begin
          if (rsp_fire) begin
            if (rsp_last) begin
              // clear buffer so a short next packet reports unreceived fields as 0
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              frame_q <= 1'b0;
              id_q    <= '0;
              fn_q    <= '0;
              ret_q   <= '0;
              addr_q  <= '0;
              n_q     <= '0;
              data_q  <= '{default: '0};
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file writes, one word per EXEC cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && state_q == StExec && op_ok && is_write && exec_cnt_q < n_small) begin
      rf[rf_idx] <= data_q[wr_sel];
    end
  end

endmodule

// File: tb/tb_s2cif_responder.sv
// Randomized self-checking bench for s2cif_responder with a packet-level model.
module tb_s2cif_responder;
  localparam int DS   = 16;
  localparam int NREG = 64;
  localparam int PKT  = DS + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_last;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        busy;

  s2cif_responder #(.DATA_SIZE(DS), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] mdl_rf [NREG];
  logic [31:0] pkt[$];
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  int exp_lat;
  int fire_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [31:0] id, input logic [31:0] fn, input logic [31:0] addr,
                       input logic [31:0] n, input int len);
    pkt = {id, fn, $urandom, addr, n};
    while (pkt.size() < len) pkt.push_back($urandom);
  endtask

  // Expected response and EXEC length from packet-level rules; updates model registers
  task automatic model(input int last_at);
    int nst;
    logic [31:0] id, fn, ret, addr, n;
    logic [31:0] d [DS];
    nst = (last_at + 1 < PKT) ? last_at + 1 : PKT;
    id = (nst > 0) ? pkt[0] : 32'd0;
    fn = (nst > 1) ? pkt[1] : 32'd0;
    for (int k = 0; k < DS; k++) d[k] = (3 + k < nst) ? pkt[3 + k] : 32'd0;
    addr = d[0];
    n = d[1];
    exp_lat = 1;
    if (last_at != PKT - 1) ret = 32'd2;
    else if (fn == 32'd0) ret = 32'd0;
    else if (fn == 32'd1) begin
      if (addr >= NREG || n > DS - 2) ret = 32'd1;
      else begin
        ret = 32'd0;
        for (int i = 0; i < int'(n); i++) mdl_rf[(int'(addr) + i) % NREG] = d[2 + i];
        exp_lat = (n == 0) ? 1 : int'(n);
      end
    end else if (fn == 32'd2) begin
      if (addr >= NREG || n > DS) begin
        ret = 32'd1;
        for (int i = 0; i < DS; i++) d[i] = 32'd0;
      end else begin
        ret = 32'd0;
        for (int i = 0; i < DS; i++)
          d[i] = (i < int'(n)) ? mdl_rf[(int'(addr) + i) % NREG] : 32'd0;
        exp_lat = (n == 0) ? 1 : int'(n);
      end
    end else ret = 32'hFFFF_FFFF;
    exp_q = {id, fn, ret};
    for (int k = 0; k < DS; k++) exp_q.push_back(d[k]);
  endtask

  task automatic send_pkt(input int last_at, input bit with_last);
    for (int b = 0; b <= last_at; b++) begin
      int guard = 0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      req_valid = 1'b1;
      req_data  = pkt[b];
      req_last  = with_last && (b == last_at);
      while (!req_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
      @(negedge clk);
      fire_cyc  = cyc;
      req_valid = 1'b0;
      req_last  = 1'b0;
      if (b == 0) check_eq("busy_after_first_beat", 32'(busy), 32'd1);
    end
  endtask

  task automatic recv(input bit bp);
    int n = 0;
    int guard = 0;
    int first = -1;
    bit stalled = 1'b0;
    bit done = 1'b0;
    logic [31:0] held = 32'd0;
    rx_q = {};
    while (!done && guard < 500) begin
      rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid) begin
        if (first < 0) begin
          first = cyc;
          check_eq("latency", 32'(first - fire_cyc), 32'(exp_lat));
        end
        check_eq("req_ready_in_tx", 32'(req_ready), 32'd0);
        if (stalled) check_eq("stall_hold", rsp_data, held);
        if (rsp_ready) begin
          rx_q.push_back(rsp_data);
          if (n < exp_q.size()) check_eq($sformatf("beat%0d", n), rsp_data, exp_q[n]);
          check_eq($sformatf("rsp_last%0d", n), 32'(rsp_last), 32'(n == exp_q.size() - 1));
          n++;
          stalled = 1'b0;
          done = rsp_last;
        end else begin
          stalled = 1'b1;
          held = rsp_data;
        end
      end
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b0;
    check_eq("rsp_beats", 32'(n), 32'(exp_q.size()));
    check_eq("busy_after_tx", 32'(busy), 32'd0);
    check_eq("req_ready_after_tx", 32'(req_ready), 32'd1);
  endtask

  task automatic run_pkt(input int last_at, input bit bp);
    model(last_at);
    send_pkt(last_at, 1'b1);
    recv(bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va, vb, vc, vd;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_last = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_last", 32'(rsp_last), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(req_ready), 32'd1);

    // Give every register a known value
    for (int base = 0; base < NREG; base += 14) begin
      int n = (NREG - base < 14) ? NREG - base : 14;
      build(32'(100 + base), 32'd1, 32'(base), 32'(n), PKT);
      run_pkt(PKT - 1, 1'b0);
    end

    // WRITE then READ of the same three registers
    build(32'd7, 32'd1, 32'd4, 32'd3, PKT);
    pkt[5] = 32'd11; pkt[6] = 32'd22; pkt[7] = 32'd33;
    run_pkt(PKT - 1, 1'b0);
    build(32'd8, 32'd2, 32'd4, 32'd3, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("t1_id", rx_q[0], 32'd8);
    check_eq("t1_fn", rx_q[1], 32'd2);
    check_eq("t1_ret", rx_q[2], 32'd0);
    check_eq("t1_d0", rx_q[3], 32'd11);
    check_eq("t1_d1", rx_q[4], 32'd22);
    check_eq("t1_d2", rx_q[5], 32'd33);
    check_eq("t1_d3", rx_q[6], 32'd0);

    // Address wrap from 63 to 0
    va = $urandom; vb = $urandom; vc = $urandom; vd = $urandom;
    build(32'd20, 32'd1, 32'd62, 32'd4, PKT);
    pkt[5] = va; pkt[6] = vb; pkt[7] = vc; pkt[8] = vd;
    run_pkt(PKT - 1, 1'b0);
    build(32'd21, 32'd2, 32'd0, 32'd2, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("wrap_d0", rx_q[3], vc);
    check_eq("wrap_d1", rx_q[4], vd);

    // Error return codes
    build(32'd30, 32'd2, 32'd64, 32'd3, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("rd_bad_addr_ret", rx_q[2], 32'd1);
    build(32'd31, 32'd1, 32'd10, 32'd15, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("wr_bad_n_ret", rx_q[2], 32'd1);
    build(32'd32, 32'd2, 32'd10, 32'd14, PKT);
    run_pkt(PKT - 1, 1'b1);
    build(32'd33, 32'd9, 32'd0, 32'd0, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("bad_fn_ret", rx_q[2], 32'hFFFF_FFFF);

    // Framing: early last, then overlong packet through DRAIN
    build(32'd40, 32'd1, 32'd4, 32'd3, 6);
    run_pkt(5, 1'b0);
    check_eq("early_last_ret", rx_q[2], 32'd2);
    build(32'd41, 32'd2, 32'd4, 32'd3, PKT);
    run_pkt(PKT - 1, 1'b0);
    build(32'd42, 32'd2, 32'd0, 32'd2, 22);
    run_pkt(21, 1'b1);
    check_eq("drain_ret", rx_q[2], 32'd2);
    check_eq("drain_beats", 32'(rx_q.size()), 32'd19);

    // Random traffic with random backpressure
    for (int t = 0; t < 60; t++) begin
      int sel = $urandom_range(0, 9);
      int last_at = PKT - 1;
      logic [31:0] fn, addr;
      fn = (sel < 2) ? 32'd0 : (sel < 6) ? 32'd1 : (sel < 9) ? 32'd2 : 32'(3 + $urandom_range(0, 100));
      addr = ($urandom_range(0, 7) == 0) ? 32'(64 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) last_at = $urandom_range(2, 25);
      build(32'(t + 200), fn, addr, 32'($urandom_range(0, 17)), (last_at + 1 > PKT) ? last_at + 1 : PKT);
      run_pkt(last_at, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a request
    build(32'd50, 32'd1, 32'd0, 32'd2, PKT);
    send_pkt(4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rx_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rx_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a response
    build(32'd51, 32'd0, 32'd1, 32'd2, PKT);
    model(PKT - 1);
    send_pkt(PKT - 1, 1'b1);
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("mid_tx_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_tx_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_tx_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_tx_ready", 32'(req_ready), 32'd1);
    build(32'd1, 32'd0, 32'd0, 32'd0, PKT);
    run_pkt(PKT - 1, 1'b0);
    check_eq("post_rst_id", rx_q[0], 32'd1);
    check_eq("post_rst_ret", rx_q[2], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
